// File: rtl/adder_tree_scheduler_pkg.sv
// adder_tree_scheduler_pkg: shared FSM state type and lane/pointer sizing helpers
package adder_tree_scheduler_pkg;
    typedef enum logic [1:0] {FILL, SUM, OUT} state_t;
    function automatic int lanes_of(input int exponent);
        return 1 << exponent;
    endfunction
    // Pointer must be able to hold LANES itself, not just LANES-1.
    function automatic int ptr_width(input int exponent);
        return $clog2(lanes_of(exponent) + 1);
    endfunction
endpackage

// File: rtl/adder_tree_scheduler_balanced_adder.sv
// BalancedAdder: combinational balanced binary adder tree over 2**EXPONENT lanes
//   i_lanes : packed lane vector, lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]
//   o_sum   : sum of all lanes, modulo 2**DATA_WIDTH
module BalancedAdder
    import adder_tree_scheduler_pkg::*;
#(
    parameter int EXPONENT   = 4,
    parameter int DATA_WIDTH = 4
) (
    input  logic [lanes_of(EXPONENT)*DATA_WIDTH-1:0] i_lanes,
    output logic [DATA_WIDTH-1:0]                    o_sum
);
    localparam int LANES = lanes_of(EXPONENT);
    // Heap-ordered tree: leaves at [LANES-1 .. 2*LANES-2], node k sums children 2k+1 and 2k+2.
    logic [DATA_WIDTH-1:0] w_node [2*LANES-1];
    always_comb begin
        for (int i = 0; i < LANES; i++) w_node[LANES-1+i] = i_lanes[i*DATA_WIDTH +: DATA_WIDTH];
        for (int k = LANES - 2; k >= 0; k--) w_node[k] = w_node[2*k+1] + w_node[2*k+2];
    end
    assign o_sum = w_node[0];
endmodule

// File: rtl/adder_tree_scheduler.sv
// adder_tree_scheduler: packs streamed terms into a lane buffer, sums each buffer with one shared tree, emits one total per transaction
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : term handshake; in_data term, in_last marks final term
//   out_valid/out_ready : total handshake; out_data total, out_count term count
//   busy                : not idle in FILL with an empty buffer
module adder_tree_scheduler
    import adder_tree_scheduler_pkg::*;
#(
    parameter int EXPONENT    = 4,
    parameter int DATA_WIDTH  = 4,
    parameter int ACC_WIDTH   = 12,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_WIDTH-1:0]   out_data,
    output logic [COUNT_WIDTH-1:0] out_count,
    output logic                   busy
);
    localparam int LANES = lanes_of(EXPONENT);
    localparam int PW    = ptr_width(EXPONENT);
    state_t                   r_state;
    logic [LANES*ACC_WIDTH-1:0] r_lanes;
    logic [PW-1:0]            r_ptr;
    logic [ACC_WIDTH-1:0]     r_acc;
    logic [COUNT_WIDTH-1:0]   r_count;
    logic                     r_last;
    logic [ACC_WIDTH-1:0]     r_out_data;
    logic [COUNT_WIDTH-1:0]   r_out_count;
    logic [ACC_WIDTH-1:0]     w_sum;
    logic [ACC_WIDTH-1:0]     w_total;
    logic                     w_take;
    BalancedAdder #(
        .EXPONENT   (EXPONENT),
        .DATA_WIDTH (ACC_WIDTH)
    ) u_tree (
        .i_lanes (r_lanes),
        .o_sum   (w_sum)
    );
    assign in_ready  = r_state == FILL;
    assign out_valid = r_state == OUT;
    assign out_data  = r_out_data;
    assign out_count = r_out_count;
    // Lanes fill strictly in order, so a nonzero pointer means some lane holds a term.
    assign busy      = r_state != FILL || r_ptr != '0;
    assign w_take    = in_valid && in_ready;
    assign w_total   = r_acc + w_sum;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= FILL;
            r_lanes     <= '0;
            r_ptr       <= '0;
            r_acc       <= '0;
            r_count     <= '0;
            r_last      <= 1'b0;
            r_out_data  <= '0;
            r_out_count <= '0;
        end else begin
            case (r_state)
                FILL: if (w_take) begin
                    r_lanes[r_ptr*ACC_WIDTH +: ACC_WIDTH] <= ACC_WIDTH'(in_data);
                    r_ptr   <= r_ptr + 1'b1;
                    r_count <= r_count + 1'b1;
                    r_last  <= in_last;
                    if (in_last || r_ptr == PW'(LANES - 1)) r_state <= SUM;
                end
                SUM: begin
                    r_acc   <= w_total;
                    // Clearing here keeps unwritten lanes at zero for a short final pass.
                    r_lanes <= '0;
                    r_ptr   <= '0;
                    r_state <= r_last ? OUT : FILL;
                    if (r_last) begin
                        r_out_data  <= w_total;
                        r_out_count <= r_count;
                    end
                end
                OUT: if (out_ready) begin
                    r_acc   <= '0;
                    r_count <= '0;
                    r_last  <= 1'b0;
                    r_state <= FILL;
                end
                default: r_state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_adder_tree_scheduler.sv
// tb_adder_tree_scheduler: directed and randomized checks of adder_tree_scheduler against a per-transaction sum model
module tb_adder_tree_scheduler;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_data = '0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic [7:0] out_count;
    logic       busy;
    int tests = 0;
    int fails = 0;
    int m_acc = 0;
    int m_cnt = 0;
    int exp_d[$];
    int exp_c[$];
    bit rnd_en = 1'b0;

    adder_tree_scheduler #(
        .EXPONENT    (2),
        .DATA_WIDTH  (4),
        .ACC_WIDTH   (8),
        .COUNT_WIDTH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Model: a transaction's total is the plain sum of its terms, reduced mod 256.
    task automatic send(input logic [3:0] d, input logic l);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_wait", n < 50, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        m_acc += int'(d);
        m_cnt++;
        if (l) begin
            exp_d.push_back(m_acc % 256);
            exp_c.push_back(m_cnt % 256);
            m_acc = 0;
            m_cnt = 0;
        end
    endtask

    task automatic expect_out(input int d, input int c);
        int n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("out_valid_wait", n < 20, 1);
        check("out_data_direct", out_data, d);
        check("out_count_direct", out_count, c);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            check("out_pending", exp_d.size() > 0, 1);
            if (exp_d.size() > 0) begin
                check("out_data", out_data, exp_d.pop_front());
                check("out_count", out_count, exp_c.pop_front());
            end
        end
    end

    always @(posedge clk) begin
        if (rnd_en) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_count", out_count, 0);
        check("rst_busy", busy, 0);

        send(4'd1, 1'b0);
        check("busy_partial", busy, 1);
        send(4'd2, 1'b0);
        send(4'd3, 1'b1);
        check("lat_sum_valid", out_valid, 0);
        check("lat_sum_ready", in_ready, 0);
        @(posedge clk); #1;
        check("lat_out_valid", out_valid, 1);
        check("lat_out_data", out_data, 6);
        check("lat_out_count", out_count, 3);
        @(posedge clk); #1;
        check("after_out_ready", in_ready, 1);

        for (int i = 0; i < 4; i++) send(4'd5, i == 3);
        check("full_last_sum", out_valid, 0);
        @(posedge clk); #1;
        check("full_last_out", out_valid, 1);
        check("full_last_data", out_data, 20);
        check("full_last_count", out_count, 4);
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            send(4'd15, i == 9);
            if (i % 4 == 3 || i == 9) check("bubble10", in_ready, 0);
        end
        expect_out(150, 10);
        @(posedge clk); #1;

        for (int i = 0; i < 20; i++) begin
            send(4'd15, i == 19);
            if (i % 4 == 3) check("bubble20", in_ready, 0);
        end
        expect_out(44, 20);
        @(posedge clk); #1;

        out_ready = 1'b0;
        send(4'd7, 1'b1);
        @(posedge clk); #1;
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", out_valid, 1);
            check("bp_data", out_data, 7);
            check("bp_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        send(4'd2, 1'b0);
        send(4'd3, 1'b1);
        expect_out(5, 2);
        @(posedge clk); #1;

        send(4'd9, 1'b0);
        send(4'd9, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_acc = 0;
        m_cnt = 0;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_count", out_count, 0);
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_busy", busy, 0);
        send(4'd7, 1'b1);
        expect_out(7, 1);
        @(posedge clk); #1;

        rnd_en = 1'b1;
        for (int t = 0; t < 30; t++) begin
            int len;
            len = int'($urandom_range(1, 12));
            for (int i = 0; i < len; i++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
                send(4'($urandom_range(0, 15)), i == len - 1);
            end
        end
        rnd_en = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        n = 0;
        while (exp_d.size() > 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", exp_d.size(), 0);
        check("final_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/adder_tree_scheduler.md
Name: adder_tree_scheduler

Overview:
- Streaming front-end that shares one combinational balanced adder tree across transactions of arbitrary length.
- Accepts summand terms over a valid/ready handshake and packs them into a 2**EXPONENT-lane buffer.
- Fires the tree once per full buffer, or on the transaction's last term, and accumulates partial sums across passes.
- Presents one total per transaction. Sits between the partial-product generator and the multiplier result register.

Parameters:
- EXPONENT, 4, tree depth; lane count LANES = 2**EXPONENT.
- DATA_WIDTH, 4, width of each incoming term.
- ACC_WIDTH, 12, width of the tree lanes, tree output and accumulator; must be >= DATA_WIDTH.
- COUNT_WIDTH, 8, width of the per-transaction term counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  term present.
- in_ready  output  1  block can accept a term this cycle.
- in_data  input  DATA_WIDTH  term, unsigned.
- in_last  input  1  qualifies the final term of a transaction.
- out_valid  output  1  total available.
- out_ready  input  1  consumer accepts the total.
- out_data  output  ACC_WIDTH  transaction total, modulo 2**ACC_WIDTH.
- out_count  output  COUNT_WIDTH  number of terms in the transaction, modulo 2**COUNT_WIDTH.
- busy  output  1  high whenever the state is not FILL, or any lane is occupied.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, rst).
- Reset: state=FILL, all lanes=0, lane pointer=0, acc=0, count=0, last_seen=0, out_valid=0, out_data=0, out_count=0, in_ready=1 on the cycle after rst is sampled high. Reset mid-transaction discards all buffered terms and the partial sum.
- Handshake: a transfer occurs when valid && ready in the same cycle. in_ready = (state==FILL). Data must not be taken when in_ready=0.
- FILL:
  - Each accepted term is zero-extended to ACC_WIDTH and written to lane[ptr]; ptr increments; count increments.
  - If ptr becomes LANES, or in_last is accepted, go to SUM next cycle; last_seen records in_last.
- SUM (exactly 1 cycle):
  - The tree input is all lanes. Lanes not written in this pass hold 0, guaranteed by clearing lanes on entry to FILL.
  - acc <= acc + tree_sum (mod 2**ACC_WIDTH). Clear lanes and ptr.
  - If last_seen, go to OUT and latch out_data = acc + tree_sum and out_count; otherwise return to FILL.
- OUT:
  - out_valid=1; out_data and out_count stable until out_ready.
  - On handshake: out_valid=0, acc=0, count=0, last_seen=0, go to FILL.
- Latency: the last term is accepted at cycle T. SUM runs at T+1; out_valid rises at T+2. A full non-last buffer returns to FILL at T+2, which is one bubble cycle per pass.
- A full buffer with in_last on the same term is a single SUM followed by OUT; no empty extra pass.
- Empty transactions do not exist: in_last always accompanies a term.
- Throughput: at most LANES terms per LANES+1 cycles.
- Tree: purely combinational. The registered acc is the only sequential point in the sum path.

Decomposition:
- Shared package holds:
  - state enum {FILL, SUM, OUT} (2-bit);
  - function lanes_of(EXPONENT) = 2**EXPONENT;
  - constant pointer width clog2(LANES+1).
- One sub-module: the team's existing balanced adder tree (BalancedAdder), instantiated with EXPONENT and DATA_WIDTH=ACC_WIDTH. The scheduler owns the lane buffer, FSM, accumulator and counters.

Test Plan:
All scenarios use EXPONENT=2 (4 lanes), DATA_WIDTH=4, ACC_WIDTH=8, COUNT_WIDTH=8, out_ready=1 unless stated.
- Terms 1,2,3 (last on 3) -> one SUM pass; out_data=6, out_count=3, out_valid exactly 2 cycles after the last term is accepted.
- Terms 5,5,5,5 (last on 4th) -> single pass, no extra pass; out_data=20, out_count=4.
- Ten terms of 15 -> passes of 4, 4, 2 terms; in_ready low for one cycle after each full buffer; out_data=150, out_count=10.
- Twenty terms of 15 -> wrap; out_data=300 mod 256=44, out_count=20.
- Backpressure: complete {7}, hold out_ready=0 for 5 cycles -> out_valid stays 1, out_data=7 stable, in_ready=0. Release, then send {2,3 last} -> out_data=5, proving acc was cleared.
- Accept 9,9, then assert rst for 1 cycle -> all outputs 0, in_ready=1, busy=0. Then send {7 last} -> out_data=7, out_count=1.
